// File: rtl/rr_lock_arbiter_pkg.sv
// rtl/rr_lock_arbiter_pkg.sv - shared arbiter state encodings and width helper
package rr_lock_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_ACK  = 2'd2,
        ARB_HOLD = 2'd3
    } arb_state_t;

    function automatic int arb_clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_pick.sv
// rtl/rr_lock_arbiter_pick.sv - round-robin pick: first eligible port after last winner, with wrap
module rr_lock_arbiter_pick
    import rr_lock_arbiter_pkg::*;
#(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 3
) (
    input  logic [PORTS-1:0]     eligible,
    input  logic [PORT_BITS-1:0] last,
    output logic                 found,
    output logic [PORT_BITS-1:0] index
);

    logic                 hi_found;
    logic                 lo_found;
    logic [PORT_BITS-1:0] hi_index;
    logic [PORT_BITS-1:0] lo_index;

    // Descending scan: the lowest eligible port above last wins, else the lowest overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_index = '0;
        lo_index = '0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                if (k > int'(last)) begin
                    hi_found = 1'b1;
                    hi_index = PORT_BITS'(k);
                end
                lo_found = 1'b1;
                lo_index = PORT_BITS'(k);
            end
        end
    end

    assign found = lo_found;
    assign index = hi_found ? hi_index : lo_index;

endmodule

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin 4-phase req/ack arbiter with port mask and packet lock
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int PORTS     = 5,
    parameter int PORT_BITS = 3,
    parameter int LOCK_EN   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PORTS-1:0]     reqs_in,
    input  logic [PORTS-1:0]     tails_in,
    input  logic [PORTS-1:0]     mask_in,
    output logic [PORTS-1:0]     acks_in,
    output logic                 req_out,
    input  logic                 ack_out,
    output logic [PORT_BITS-1:0] selected,
    output logic                 active,
    output logic                 tail_out
);

    localparam int                CNT_W       = arb_clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_LIMIT = CNT_W'(MAX_BURST);

    arb_state_t           state, state_nxt;
    logic [PORT_BITS-1:0] last, last_nxt, sel_nxt, pick_index;
    logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
    logic [PORTS-1:0]     acks_nxt, sel_onehot;
    logic                 req_nxt, active_nxt, tail_nxt;
    logic                 pick_found, req_sel, mask_sel, release_done;

    rr_lock_arbiter_pick #(
        .PORTS     (PORTS),
        .PORT_BITS (PORT_BITS)
    ) u_pick (
        .eligible (reqs_in & mask_in),
        .last     (last),
        .found    (pick_found),
        .index    (pick_index)
    );

    assign req_sel    = reqs_in[selected];
    assign mask_sel   = mask_in[selected];
    assign sel_onehot = PORTS'(1) << selected;
    assign cnt_inc    = cnt + CNT_W'(1);
    // The mask is only honoured at handshake boundaries, never mid-handshake.
    assign release_done = (LOCK_EN == 0) || tail_out || (cnt_inc == BURST_LIMIT) || !mask_sel;

    always_comb begin
        state_nxt  = state;
        sel_nxt    = selected;
        last_nxt   = last;
        cnt_nxt    = cnt;
        req_nxt    = req_out;
        acks_nxt   = acks_in;
        active_nxt = active;
        tail_nxt   = tail_out;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    sel_nxt    = pick_index;
                    req_nxt    = 1'b1;
                    active_nxt = 1'b1;
                    tail_nxt   = tails_in[pick_index];
                    cnt_nxt    = '0;
                    state_nxt  = ARB_REQ;
                end
            end
            ARB_REQ: begin
                req_nxt  = req_sel;
                acks_nxt = ack_out ? sel_onehot : '0;
                if (ack_out) begin
                    state_nxt = ARB_ACK;
                end else if (!req_sel) begin
                    active_nxt = 1'b0;
                    state_nxt  = ARB_IDLE;
                end
            end
            ARB_ACK: begin
                req_nxt  = req_sel;
                acks_nxt = ack_out ? sel_onehot : '0;
                if (!req_sel && !ack_out) begin
                    cnt_nxt = cnt_inc;
                    if (release_done) begin
                        active_nxt = 1'b0;
                        last_nxt   = selected;
                        state_nxt  = ARB_IDLE;
                    end else begin
                        state_nxt = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                if (!mask_sel) begin
                    active_nxt = 1'b0;
                    last_nxt   = selected;
                    state_nxt  = ARB_IDLE;
                end else if (req_sel) begin
                    req_nxt   = 1'b1;
                    tail_nxt  = tails_in[selected];
                    state_nxt = ARB_REQ;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            selected <= '0;
            last     <= PORT_BITS'(PORTS - 1);
            cnt      <= '0;
            req_out  <= 1'b0;
            acks_in  <= '0;
            active   <= 1'b0;
            tail_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            selected <= sel_nxt;
            last     <= last_nxt;
            cnt      <= cnt_nxt;
            req_out  <= req_nxt;
            acks_in  <= acks_nxt;
            active   <= active_nxt;
            tail_out <= tail_nxt;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb/tb_rr_lock_arbiter.sv - bench: locked and unlocked arbiters against a behavioural model
module tb_rr_lock_arbiter;

    localparam int P = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] reqs_in = '0, tails_in = '0, mask_in = '0;
    logic       ack_out = 1'b0;

    logic [4:0] acks0, acks1;
    logic       req0, req1, act0, act1, tail0, tail1;
    logic [2:0] sel0, sel1;

    rr_lock_arbiter #(.PORTS(5), .PORT_BITS(3), .LOCK_EN(1), .MAX_BURST(3)) u_lock (
        .clk(clk), .reset(reset), .reqs_in(reqs_in), .tails_in(tails_in), .mask_in(mask_in),
        .acks_in(acks0), .req_out(req0), .ack_out(ack_out), .selected(sel0), .active(act0),
        .tail_out(tail0)
    );

    rr_lock_arbiter #(.PORTS(5), .PORT_BITS(3), .LOCK_EN(0), .MAX_BURST(8)) u_free (
        .clk(clk), .reset(reset), .reqs_in(reqs_in), .tails_in(tails_in), .mask_in(mask_in),
        .acks_in(acks1), .req_out(req1), .ack_out(ack_out), .selected(sel1), .active(act1),
        .tail_out(tail1)
    );

    always #5 clk = ~clk;

    // phase: 0 waiting for ack, 1 acked, 2 locked between handshakes
    typedef struct {
        bit       busy;
        int       phase;
        int       owner;
        int       last;
        int       done;
        bit       rq;
        bit [4:0] ak;
        bit       tl;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.busy = 0; m.phase = 0; m.owner = 0; m.last = P - 1; m.done = 0;
        m.rq = 0; m.ak = '0; m.tl = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic [4:0] rq, input logic [4:0] tl,
                                      input logic [4:0] mk, input logic ak,
                                      input int lock_en, input int max_burst);
        mdl_t n;
        int   o;
        int   j;
        bit   got;
        n = m;
        o = m.owner;
        got = 0;
        if (!m.busy) begin
            for (int d = 1; d <= P; d++) begin
                j = (m.last + d) % P;
                if (!got && rq[j] && mk[j]) begin
                    got = 1;
                    n.busy = 1; n.owner = j; n.phase = 0; n.rq = 1; n.tl = tl[j];
                    n.done = 0; n.ak = '0;
                end
            end
        end else if (m.phase == 2) begin
            if (!mk[o]) begin
                n.busy = 0; n.last = o;
            end else if (rq[o]) begin
                n.rq = 1; n.tl = tl[o]; n.phase = 0;
            end
        end else begin
            n.rq = rq[o];
            n.ak = ak ? 5'(1 << o) : 5'b0;
            if (m.phase == 0) begin
                if (ak) n.phase = 1;
                else if (!rq[o]) n.busy = 0;
            end else if (!rq[o] && !ak) begin
                n.done = m.done + 1;
                if (lock_en == 0 || m.tl || n.done == max_burst || !mk[o]) begin
                    n.busy = 0; n.last = o;
                end else begin
                    n.phase = 2;
                end
            end
        end
        return n;
    endfunction

    mdl_t m_lock, m_free;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lock <= mdl_reset();
            m_free <= mdl_reset();
        end else begin
            m_lock <= mdl_step(m_lock, reqs_in, tails_in, mask_in, ack_out, 1, 3);
            m_free <= mdl_step(m_free, reqs_in, tails_in, mask_in, ack_out, 0, 8);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, exp);
        end
    endtask

    task automatic chk_model(input string nm, input mdl_t m, input logic [4:0] ak, input logic rq,
                             input logic [2:0] sl, input logic ac, input logic tl);
        checks++;
        if ({ak, rq, sl, ac, tl} !== {m.ak, m.rq, 3'(m.owner), m.busy, m.tl}) begin
            failures++;
            $display("FAIL model_%s t=%0t got acks=%b req=%b sel=%0d active=%b tail=%b expected acks=%b req=%b sel=%0d active=%b tail=%b",
                     nm, $time, ak, rq, sl, ac, tl, m.ak, m.rq, m.owner, m.busy, m.tl);
        end
    endtask

    always @(negedge clk) begin
        chk_model("lock", m_lock, acks0, req0, sel0, act0, tail0);
        chk_model("free", m_free, acks1, req1, sel1, act1, tail1);
    end

    int         comp_q[$];
    int         done_cnt[P];
    logic [4:0] prev_acks;

    task automatic do_reset();
        reset = 1'b1;
        reqs_in = '0; tails_in = '0; mask_in = '0; ack_out = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        comp_q.delete();
        prev_acks = '0;
        for (int k = 0; k < P; k++) done_cnt[k] = 0;
    endtask

    // Clients drop req on ack and re-raise once ack falls; downstream ack mirrors req_out.
    task automatic run_env(input int target, input int cycles, input logic [4:0] want,
                           input int tail_port, input int tail_at);
        logic [4:0] ta;
        logic       tr;
        logic [2:0] ts;
        for (int c = 0; c < cycles; c++) begin
            ta = (target == 0) ? acks0 : acks1;
            tr = (target == 0) ? req0 : req1;
            ts = (target == 0) ? sel0 : sel1;
            if (prev_acks != 0 && ta == 0) begin
                comp_q.push_back(int'(ts));
                done_cnt[ts]++;
            end
            prev_acks = ta;
            ack_out = tr;
            reqs_in = want & ~ta;
            mask_in = '1;
            for (int k = 0; k < P; k++) tails_in[k] = (k == tail_port) && (done_cnt[k] == tail_at);
            @(negedge clk);
        end
    endtask

    task automatic check_seq(input string nm, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            chk($sformatf("%s[%0d]", nm, i), (i < comp_q.size()) ? comp_q[i] : -1, exp[i]);
        end
    endtask

    typedef struct {
        logic [4:0] rq, tl, mk;
        logic       ak;
        logic [4:0] e_acks;
        logic       e_req;
        int         e_sel;
        logic       e_act;
        logic       e_tail;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // Mask, lock with tail release, idle hold, abort, ack rise with mask drop (locked instance)
        tbl[0]  = '{5'b00110, 5'b00000, 5'b11011, 1'b0, 5'b00000, 1'b1, 1, 1'b1, 1'b0};
        tbl[1]  = '{5'b00110, 5'b00000, 5'b11011, 1'b1, 5'b00010, 1'b1, 1, 1'b1, 1'b0};
        tbl[2]  = '{5'b00100, 5'b00000, 5'b11011, 1'b1, 5'b00010, 1'b0, 1, 1'b1, 1'b0};
        tbl[3]  = '{5'b00100, 5'b00000, 5'b11011, 1'b0, 5'b00000, 1'b0, 1, 1'b1, 1'b0};
        tbl[4]  = '{5'b00110, 5'b00010, 5'b11011, 1'b0, 5'b00000, 1'b1, 1, 1'b1, 1'b1};
        tbl[5]  = '{5'b00110, 5'b00000, 5'b11011, 1'b1, 5'b00010, 1'b1, 1, 1'b1, 1'b1};
        tbl[6]  = '{5'b00100, 5'b00000, 5'b11011, 1'b1, 5'b00010, 1'b0, 1, 1'b1, 1'b1};
        tbl[7]  = '{5'b00100, 5'b00000, 5'b11011, 1'b0, 5'b00000, 1'b0, 1, 1'b0, 1'b1};
        tbl[8]  = '{5'b00100, 5'b00000, 5'b11011, 1'b0, 5'b00000, 1'b0, 1, 1'b0, 1'b1};
        tbl[9]  = '{5'b00100, 5'b00000, 5'b11111, 1'b0, 5'b00000, 1'b1, 2, 1'b1, 1'b0};
        tbl[10] = '{5'b00000, 5'b00000, 5'b11111, 1'b0, 5'b00000, 1'b0, 2, 1'b0, 1'b0};
        tbl[11] = '{5'b00100, 5'b00000, 5'b11111, 1'b0, 5'b00000, 1'b1, 2, 1'b1, 1'b0};
        tbl[12] = '{5'b00100, 5'b00000, 5'b11011, 1'b1, 5'b00100, 1'b1, 2, 1'b1, 1'b0};
        tbl[13] = '{5'b00000, 5'b00000, 5'b11011, 1'b1, 5'b00100, 1'b0, 2, 1'b1, 1'b0};
        tbl[14] = '{5'b00000, 5'b00000, 5'b11011, 1'b0, 5'b00000, 1'b0, 2, 1'b0, 1'b0};
        tbl[15] = '{5'b00100, 5'b00000, 5'b11011, 1'b0, 5'b00000, 1'b0, 2, 1'b0, 1'b0};

        #1;
        do_reset();
        chk("reset_req", int'(req0), 0);
        chk("reset_active", int'(act0), 0);
        chk("reset_sel", int'(sel0), 0);

        for (int i = 0; i < 16; i++) begin
            reqs_in = tbl[i].rq; tails_in = tbl[i].tl; mask_in = tbl[i].mk; ack_out = tbl[i].ak;
            @(negedge clk);
            chk($sformatf("vec%0d_acks", i), int'(acks0), int'(tbl[i].e_acks));
            chk($sformatf("vec%0d_req", i), int'(req0), int'(tbl[i].e_req));
            chk($sformatf("vec%0d_sel", i), int'(sel0), tbl[i].e_sel);
            chk($sformatf("vec%0d_active", i), int'(act0), int'(tbl[i].e_act));
            chk($sformatf("vec%0d_tail", i), int'(tail0), int'(tbl[i].e_tail));
        end

        // Reset in the middle of an acknowledged handshake
        reqs_in = 5'b00001; mask_in = 5'b11111; tails_in = '0; ack_out = 1'b0;
        @(negedge clk);
        ack_out = 1'b1;
        @(negedge clk);
        chk("pre_reset_acks", int'(acks0), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_acks", int'(acks0), 0);
        chk("async_reset_req", int'(req0), 0);
        chk("async_reset_active", int'(act0), 0);
        @(negedge clk);
        reset = 1'b0;
        reqs_in = 5'b01010; ack_out = 1'b0;
        @(negedge clk);
        chk("post_reset_sel", int'(sel0), 1);
        chk("post_reset_req", int'(req0), 1);

        do_reset();
        run_env(1, 60, 5'b11111, -1, 0);
        check_seq("fair", '{0, 1, 2, 3, 4, 0});

        do_reset();
        run_env(0, 1, 5'b01000, -1, 0);
        run_env(0, 40, 5'b01001, 3, 1);
        check_seq("lock", '{3, 3, 0});

        do_reset();
        run_env(0, 1, 5'b00010, -1, 0);
        run_env(0, 100, 5'b00111, -1, 0);
        check_seq("burst", '{1, 1, 1, 2, 2, 2, 0, 0, 0, 1});

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom_range(0, 299) == 0);
            reqs_in  = 5'($urandom);
            tails_in = 5'($urandom);
            mask_in  = 5'($urandom | $urandom);
            ack_out  = 1'($urandom);
            @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
